// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: first-word-fall-through instruction/PC FIFO between fetch and decode
module inst_fetch_queue #(
    parameter int INST_WIDTH   = 32,
    parameter int PC_WIDTH     = 32,
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_THRESH = (1 << DEPTH_LOG2) - 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush_in,
    input  logic                  enq_valid_in,
    input  logic [INST_WIDTH-1:0] enq_inst_in,
    input  logic [PC_WIDTH-1:0]   enq_pc_in,
    output logic                  enq_ready_out,
    output logic                  deq_valid_out,
    output logic [INST_WIDTH-1:0] deq_inst_out,
    output logic [PC_WIDTH-1:0]   deq_pc_out,
    input  logic                  deq_ready_in,
    output logic [DEPTH_LOG2:0]   count_out,
    output logic                  almost_full_out,
    output logic                  empty_out
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LP_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LP_AFULL = (DEPTH_LOG2 + 1)'(AFULL_THRESH);

    logic [INST_WIDTH-1:0] r_inst [DEPTH];
    logic [PC_WIDTH-1:0]   r_pc   [DEPTH];
    logic [DEPTH_LOG2-1:0] r_head;
    logic [DEPTH_LOG2-1:0] r_tail;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_flush;

    // Handshakes and status; reset also masks enq_ready so nothing is accepted while held in reset
    always_comb begin
        enq_ready_out   = rst_n_in & rdy_in & (r_count != LP_DEPTH);
        deq_valid_out   = rdy_in & (r_count != '0);
        deq_inst_out    = r_inst[r_head];
        deq_pc_out      = r_pc[r_head];
        count_out       = r_count;
        almost_full_out = r_count >= LP_AFULL;
        empty_out       = r_count == '0;
        w_flush         = rdy_in & flush_in;
        w_enq           = enq_valid_in & enq_ready_out & ~w_flush;
        w_deq           = deq_valid_out & deq_ready_in & ~w_flush;
    end

    // Entry storage is written at the tail and never reset
    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_inst[r_tail] <= enq_inst_in;
            r_pc[r_tail]   <= enq_pc_in;
        end
    end

    // Pointers and occupancy; flush takes priority over both handshakes
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            if (w_enq && !w_deq) r_count <= r_count + 1'b1;
            else if (w_deq && !w_enq) r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        enq_valid_in;
    logic [31:0] enq_inst_in;
    logic [31:0] enq_pc_in;
    logic        enq_ready_out;
    logic        deq_valid_out;
    logic [31:0] deq_inst_out;
    logic [31:0] deq_pc_out;
    logic        deq_ready_in;
    logic [4:0]  count_out;
    logic        almost_full_out;
    logic        empty_out;
    int          checks = 0;
    int          passes = 0;

    inst_fetch_queue dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .enq_valid_in(enq_valid_in), .enq_inst_in(enq_inst_in), .enq_pc_in(enq_pc_in),
        .enq_ready_out(enq_ready_out), .deq_valid_out(deq_valid_out),
        .deq_inst_out(deq_inst_out), .deq_pc_out(deq_pc_out), .deq_ready_in(deq_ready_in),
        .count_out(count_out), .almost_full_out(almost_full_out), .empty_out(empty_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic enq_n(input int n, input logic [31:0] base);
        enq_valid_in = 1'b1;
        deq_ready_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            enq_inst_in = base + 32'(i);
            enq_pc_in   = 32'(4 * i);
            tick();
        end
        enq_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        enq_valid_in = 1'b0; deq_ready_in = 1'b0; enq_inst_in = '0; enq_pc_in = '0;
        #2;
        checks++; if (enq_ready_out !== 1'b0) $display("FAIL rst_enq_ready got %b exp 0", enq_ready_out); else passes++;
        checks++; if (deq_valid_out !== 1'b0) $display("FAIL rst_deq_valid got %b exp 0", deq_valid_out); else passes++;
        checks++; if (count_out !== 5'd0) $display("FAIL rst_count got %0d exp 0", count_out); else passes++;
        checks++; if (empty_out !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty_out); else passes++;
        checks++; if (almost_full_out !== 1'b0) $display("FAIL rst_afull got %b exp 0", almost_full_out); else passes++;
        tick();
        rst_n_in = 1'b1;
        tick();
        checks++; if (enq_ready_out !== 1'b1) $display("FAIL post_rst_enq_ready got %b exp 1", enq_ready_out); else passes++;
    endtask

    task automatic test_fill_drain();
        enq_valid_in = 1'b1;
        deq_ready_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            enq_inst_in = 32'h1000 + 32'(i);
            enq_pc_in   = 32'(4 * i);
            #1;
            checks++; if (enq_ready_out !== 1'b1) $display("FAIL fill_enq_ready[%0d] got %b exp 1", i, enq_ready_out); else passes++;
            checks++; if (almost_full_out !== (i >= 14)) $display("FAIL fill_afull[%0d] got %b exp %b", i, almost_full_out, i >= 14); else passes++;
            tick();
        end
        enq_valid_in = 1'b0;
        checks++; if (count_out !== 5'd16) $display("FAIL full_count got %0d exp 16", count_out); else passes++;
        checks++; if (enq_ready_out !== 1'b0) $display("FAIL full_enq_ready got %b exp 0", enq_ready_out); else passes++;
        checks++; if (almost_full_out !== 1'b1) $display("FAIL full_afull got %b exp 1", almost_full_out); else passes++;
        deq_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (deq_valid_out !== 1'b1) $display("FAIL drain_valid[%0d] got %b exp 1", i, deq_valid_out); else passes++;
            checks++; if (deq_inst_out !== 32'h1000 + 32'(i)) $display("FAIL drain_inst[%0d] got %h exp %h", i, deq_inst_out, 32'h1000 + 32'(i)); else passes++;
            checks++; if (deq_pc_out !== 32'(4 * i)) $display("FAIL drain_pc[%0d] got %h exp %h", i, deq_pc_out, 32'(4 * i)); else passes++;
            tick();
        end
        deq_ready_in = 1'b0;
        checks++; if (empty_out !== 1'b1) $display("FAIL drain_empty got %b exp 1", empty_out); else passes++;
        checks++; if (count_out !== 5'd0) $display("FAIL drain_count got %0d exp 0", count_out); else passes++;
    endtask

    task automatic test_wrap();
        enq_n(10, 32'h2000);
        deq_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (deq_inst_out !== 32'h2000 + 32'(i)) $display("FAIL wrap1_inst[%0d] got %h exp %h", i, deq_inst_out, 32'h2000 + 32'(i)); else passes++;
            tick();
        end
        enq_n(12, 32'h3000);
        checks++; if (count_out !== 5'd12) $display("FAIL wrap_count12 got %0d exp 12", count_out); else passes++;
        deq_ready_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++; if (deq_inst_out !== 32'h3000 + 32'(i)) $display("FAIL wrap2_inst[%0d] got %h exp %h", i, deq_inst_out, 32'h3000 + 32'(i)); else passes++;
            checks++; if (deq_pc_out !== 32'(4 * i)) $display("FAIL wrap2_pc[%0d] got %h exp %h", i, deq_pc_out, 32'(4 * i)); else passes++;
            tick();
        end
        deq_ready_in = 1'b0;
        checks++; if (count_out !== 5'd0) $display("FAIL wrap_count_end got %0d exp 0", count_out); else passes++;
    endtask

    task automatic test_back_to_back();
        enq_n(1, 32'hA0);
        enq_valid_in = 1'b1; deq_ready_in = 1'b1; enq_inst_in = 32'hB0; enq_pc_in = 32'h44;
        #1;
        checks++; if (deq_inst_out !== 32'hA0) $display("FAIL b2b_head_before got %h exp a0", deq_inst_out); else passes++;
        tick();
        enq_valid_in = 1'b0; deq_ready_in = 1'b0;
        checks++; if (count_out !== 5'd1) $display("FAIL b2b_count1 got %0d exp 1", count_out); else passes++;
        checks++; if (deq_inst_out !== 32'hB0) $display("FAIL b2b_head_after got %h exp b0", deq_inst_out); else passes++;
        checks++; if (deq_pc_out !== 32'h44) $display("FAIL b2b_pc_after got %h exp 44", deq_pc_out); else passes++;
        deq_ready_in = 1'b1;
        tick();
        enq_n(16, 32'hC00);
        enq_valid_in = 1'b1; deq_ready_in = 1'b1; enq_inst_in = 32'hDEAD; enq_pc_in = '0;
        #1;
        checks++; if (enq_ready_out !== 1'b0) $display("FAIL b2b_full_enq_ready got %b exp 0", enq_ready_out); else passes++;
        tick();
        enq_valid_in = 1'b0;
        checks++; if (count_out !== 5'd15) $display("FAIL b2b_full_count got %0d exp 15", count_out); else passes++;
        checks++; if (deq_inst_out !== 32'hC01) $display("FAIL b2b_full_head got %h exp c01", deq_inst_out); else passes++;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (deq_inst_out !== 32'hC0F) $display("FAIL b2b_last_inst got %h exp c0f", deq_inst_out); else passes++;
        tick();
        deq_ready_in = 1'b0;
        checks++; if (empty_out !== 1'b1) $display("FAIL b2b_no_dead_empty got %b exp 1", empty_out); else passes++;
    endtask

    task automatic test_flush();
        enq_n(7, 32'h4000);
        flush_in = 1'b1; enq_valid_in = 1'b1; deq_ready_in = 1'b1; enq_inst_in = 32'hF1; enq_pc_in = '0;
        tick();
        flush_in = 1'b0; enq_valid_in = 1'b0; deq_ready_in = 1'b0;
        checks++; if (count_out !== 5'd0) $display("FAIL flush_count got %0d exp 0", count_out); else passes++;
        checks++; if (deq_valid_out !== 1'b0) $display("FAIL flush_deq_valid got %b exp 0", deq_valid_out); else passes++;
        enq_n(1, 32'h5555);
        checks++; if (count_out !== 5'd1) $display("FAIL flush_post_count got %0d exp 1", count_out); else passes++;
        checks++; if (deq_inst_out !== 32'h5555) $display("FAIL flush_post_head got %h exp 5555", deq_inst_out); else passes++;
        deq_ready_in = 1'b1;
        tick();
        deq_ready_in = 1'b0;
    endtask

    task automatic test_pause();
        enq_n(5, 32'h6000);
        rdy_in = 1'b0; enq_valid_in = 1'b1; deq_ready_in = 1'b1; flush_in = 1'b1; enq_inst_in = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (enq_ready_out !== 1'b0) $display("FAIL pause_enq_ready[%0d] got %b exp 0", i, enq_ready_out); else passes++;
            checks++; if (deq_valid_out !== 1'b0) $display("FAIL pause_deq_valid[%0d] got %b exp 0", i, deq_valid_out); else passes++;
            checks++; if (count_out !== 5'd5) $display("FAIL pause_count[%0d] got %0d exp 5", i, count_out); else passes++;
            tick();
        end
        rdy_in = 1'b1; enq_valid_in = 1'b0; deq_ready_in = 1'b0; flush_in = 1'b0;
        #1;
        checks++; if (count_out !== 5'd5) $display("FAIL resume_count got %0d exp 5", count_out); else passes++;
        checks++; if (deq_valid_out !== 1'b1) $display("FAIL resume_valid got %b exp 1", deq_valid_out); else passes++;
        checks++; if (deq_inst_out !== 32'h6000) $display("FAIL resume_head got %h exp 6000", deq_inst_out); else passes++;
        deq_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        deq_ready_in = 1'b0;
        checks++; if (empty_out !== 1'b1) $display("FAIL pause_drain_empty got %b exp 1", empty_out); else passes++;
    endtask

    task automatic test_async_reset();
        enq_n(9, 32'h7000);
        checks++; if (count_out !== 5'd9) $display("FAIL areset_pre_count got %0d exp 9", count_out); else passes++;
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++; if (count_out !== 5'd0) $display("FAIL areset_count got %0d exp 0", count_out); else passes++;
        checks++; if (deq_valid_out !== 1'b0) $display("FAIL areset_deq_valid got %b exp 0", deq_valid_out); else passes++;
        checks++; if (empty_out !== 1'b1) $display("FAIL areset_empty got %b exp 1", empty_out); else passes++;
        #2;
        rst_n_in = 1'b1;
        tick();
        enq_n(1, 32'h7777);
        checks++; if (deq_inst_out !== 32'h7777) $display("FAIL areset_new_head got %h exp 7777", deq_inst_out); else passes++;
        checks++; if (count_out !== 5'd1) $display("FAIL areset_new_count got %0d exp 1", count_out); else passes++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_pause();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Parametrised FIFO between instruction fetch (icache/memory interface) and decode/dispatch. It buffers each fetched instruction together with its PC, using valid/ready handshakes on both sides. Every entry is usable, and the block reports occupancy and almost-full for fetch throttling. A single-cycle flush discards all entries on branch mispredict or exception.

Parameters:
INST_WIDTH, 32, instruction word width in bits
PC_WIDTH, 32, width of the PC stored with each instruction
DEPTH_LOG2, 4, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (range 1..6)
AFULL_THRESH, DEPTH-2, almost_full_out asserts when count >= AFULL_THRESH

Ports:
clk_in  input  1  system clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; low pauses the block
flush_in  input  1  discard all entries (synchronous)
enq_valid_in  input  1  fetch presents an instruction
enq_inst_in  input  INST_WIDTH  instruction word
enq_pc_in  input  PC_WIDTH  PC of that instruction
enq_ready_out  output  1  queue can accept this cycle
deq_valid_out  output  1  head entry valid
deq_inst_out  output  INST_WIDTH  head instruction
deq_pc_out  output  PC_WIDTH  head PC
deq_ready_in  input  1  consumer (ROB/decode) takes head this cycle
count_out  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
almost_full_out  output  1  count_out >= AFULL_THRESH
empty_out  output  1  count_out == 0

Behaviour:
- State: head_ptr and tail_ptr, each DEPTH_LOG2 bits with natural wrap; count register DEPTH_LOG2+1 bits. Full means count == DEPTH, so all DEPTH entries are usable.
- Reset (rst_n_in low, asynchronous): head = tail = count = 0 immediately. Outputs during reset: enq_ready_out=0, deq_valid_out=0, count_out=0, empty_out=1, almost_full_out=0. Storage contents are don't-care and are not reset.
- enq_ready_out = rdy_in & (count != DEPTH). It does not depend on deq_ready_in, so there is no comb path from consumer to producer.
- deq_valid_out = rdy_in & (count != 0).
- deq_inst_out and deq_pc_out are read combinationally from the head entry (first-word fall-through). They are don't-care when deq_valid_out=0.
- An enqueue fires when enq_valid_in & enq_ready_out: write the entry at tail; tail+1.
- A dequeue fires when deq_valid_out & deq_ready_in: head+1.
- Both fire in one cycle: count unchanged, both pointers advance. If count was 1, the new entry becomes head next cycle.
- Dequeue/enqueue latency: an instruction enqueued at edge N is visible on deq_* at cycle N+1 (no same-cycle bypass when empty).
- Full plus deq_ready_in: the dequeue fires, but enqueue does not (enq_ready_out already 0). One free slot appears next cycle.
- flush_in with rdy_in high: at the next edge head = tail = count = 0. Any enqueue or dequeue in the same cycle is ignored; flush has priority. Outputs are not gated in the flush cycle, but the consumer must ignore them.
- rdy_in low: no state changes. Flush is ignored; ready/valid are forced to 0, so no handshakes fire. count_out, empty_out and almost_full_out still reflect the held state.
- Pointer wrap: DEPTH-1 -> 0 by natural overflow; there are no special cases.
- count_out, almost_full_out and empty_out are derived combinationally from the count register.

Test Plan:
- Fill/drain: DEPTH=16; enqueue 16 instructions (inst=0x1000+i, pc=4*i) with deq_ready_in=0 -> count_out=16, enq_ready_out=0 after the 16th, almost_full_out=1 from count 14. Then drain -> outputs appear in order i=0..15, empty_out=1 at the end.
- Wrap-around: enqueue 10, dequeue 10, enqueue 12, dequeue 12 -> data order preserved across the pointer wrap, count_out returns to 0.
- Simultaneous enq/deq at count=1 and at count=16: count=1 -> count stays 1 and the head becomes the new entry; count=16 -> count goes to 15 and the enqueue is not accepted.
- Flush: with 7 entries, assert flush_in together with enq_valid_in and deq_ready_in -> next cycle count_out=0, deq_valid_out=0, and the flushed-cycle enqueue is absent.
- Pause: with 5 entries, drive rdy_in=0 for 3 cycles with enq_valid_in=1, deq_ready_in=1, flush_in=1 -> count stays 5 and no handshake fires. After rdy_in returns high, resume at the same head instruction.
- Async reset mid-operation: with 9 entries, pull rst_n_in low between clock edges -> count_out=0 and deq_valid_out=0 before the next edge. After release, the first new enqueue appears at the head.
